// File: rtl/simd_pkg.sv
// Shared SIMD memory-sequencer defaults and the vector mem-op state encoding.
package simd_pkg;

  localparam int VMEM_LANES  = 8;
  localparam int VMEM_ELEM_W = 32;
  localparam int VMEM_ADDR_W = 32;

  typedef enum logic [1:0] {IDLE, XFER, DONE} vmem_state_t;

endpackage

// File: rtl/vmem_sequencer.sv
// Splits one vector load/store into LANES word beats on the data port; busy stalls the pipe
// from the start cycle through the last acked beat (LANES+1 cycles zero-wait); beats wait on mem_ack.
module vmem_sequencer
  import simd_pkg::*;
#(
  parameter int LANES  = VMEM_LANES,
  parameter int ELEM_W = VMEM_ELEM_W,
  parameter int ADDR_W = VMEM_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*ELEM_W-1:0] vdata_in,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [ELEM_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic [ELEM_W-1:0]       mem_rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    vwrite_en,
  output logic [LANES*ELEM_W-1:0] vdata_out,
  output logic                    err
);

  localparam int BEAT_W = $clog2(LANES);

  vmem_state_t state, stateNext;

  logic [BEAT_W-1:0]            beat;
  logic                         latStore;
  logic [ADDR_W-1:0]            latBase;
  logic [LANES-1:0][ELEM_W-1:0] latData;
  logic [LANES-1:0][ELEM_W-1:0] shadow;
  logic [LANES-1:0][ELEM_W-1:0] vdataQ;
  logic                         errQ;
  logic                         aligned;
  logic                         lastBeat;

  assign aligned  = (base_addr[1:0] == 2'b00);
  assign lastBeat = (beat == BEAT_W'(LANES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start && aligned) stateNext = XFER;
      XFER:    if (mem_ack && lastBeat) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat     <= '0;
      latStore <= 1'b0;
      latBase  <= '0;
      latData  <= '0;
      shadow   <= '0;
      vdataQ   <= '0;
      errQ     <= 1'b0;
    end else begin
      errQ <= (state == IDLE) && start && !aligned;
      unique case (state)
        IDLE: begin
          if (start && aligned) begin
            latStore <= is_store;
            latBase  <= base_addr;
            latData  <= vdata_in;
            beat     <= '0;
          end
        end
        XFER: begin
          if (mem_ack) begin
            if (!latStore) shadow[beat] <= mem_rdata;
            if (!lastBeat) beat <= beat + BEAT_W'(1);
          end
        end
        DONE: begin
          if (!latStore) vdataQ <= shadow;
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = (state == XFER);
  assign mem_we    = mem_req && latStore;
  assign mem_addr  = mem_req ? latBase + (ADDR_W'(beat) << 2) : '0;
  assign mem_wdata = mem_req ? latData[beat] : '0;
  assign busy      = mem_req || ((state == IDLE) && start && aligned);
  assign done      = (state == DONE);
  assign vwrite_en = done && !latStore;
  assign err       = errQ;
  // Forward the shadow during DONE so the W-stage write sees the new vector with vwrite_en.
  assign vdata_out = (done && !latStore) ? shadow : vdataQ;

endmodule

// File: tb/tb_vmem_sequencer.sv
// Randomized self-checking bench for vmem_sequencer against a beat-level memory/vector model.
module tb_vmem_sequencer;

  localparam int LANES = 8;
  localparam int EW    = 32;
  localparam int AW    = 32;
  localparam int VW    = LANES * EW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          is_store = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [VW-1:0] vdata_in = '0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [EW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [EW-1:0] mem_rdata = '0;
  logic          busy, done, vwrite_en, err;
  logic [VW-1:0] vdata_out;

  always #5 clk = ~clk;

  vmem_sequencer #(.LANES(LANES), .ELEM_W(EW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .base_addr(base_addr), .vdata_in(vdata_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .vwrite_en(vwrite_en), .vdata_out(vdata_out), .err(err)
  );

  int nChecks = 0;
  int nFails  = 0;
  logic [VW-1:0] modelVdata = '0;

  logic [AW-1:0] rAddr[$];
  logic          rWe[$];
  logic [EW-1:0] rWdata[$];
  int            rBeat[$];
  int busyCycles, doneCycle, doneCount, vwenCount, vwenOffDone, errCycle, errCount;
  logic [VW-1:0] vdataAtDone;
  logic abortReqLow, abortBusyLow;

  // One operation: start in cycle 0, memory acks every period-th request cycle.
  task automatic runOp(input logic isStore, input logic [AW-1:0] base, input logic [VW-1:0] wvec,
                       input logic [VW-1:0] rvec, input int period, input bit holdStart,
                       input int abortBeat, input int maxCycles);
    int acks = 0;
    int reqCnt = 0;
    bit ack;
    rAddr.delete(); rWe.delete(); rWdata.delete(); rBeat.delete();
    busyCycles = 0; doneCycle = -1; doneCount = 0; vwenCount = 0; vwenOffDone = 0;
    errCycle = -1; errCount = 0; vdataAtDone = '0; abortReqLow = 1'b0; abortBusyLow = 1'b0;
    for (int cyc = 0; cyc < maxCycles; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (holdStart && doneCycle < 0);
      if (start) begin
        is_store = isStore; base_addr = base; vdata_in = wvec;
      end else begin
        is_store = 1'($urandom); base_addr = $urandom;
        for (int l = 0; l < LANES; l++) vdata_in[l*EW +: EW] = $urandom;
      end
      mem_ack = 1'b0;
      #1;
      if (mem_req === 1'b1) begin
        if (abortBeat >= 0 && acks == abortBeat) begin
          reset = 1'b0;
          #1;
          abortReqLow  = (mem_req === 1'b0);
          abortBusyLow = (busy === 1'b0);
          @(negedge clk);
          reset = 1'b1; start = 1'b0;
          return;
        end
        ack = ((reqCnt % period) == period - 1);
        rAddr.push_back(mem_addr); rWe.push_back(mem_we);
        rWdata.push_back(mem_wdata); rBeat.push_back(acks);
        reqCnt++;
        mem_ack   = ack;
        mem_rdata = ack ? rvec[acks*EW +: EW] : $urandom;
        if (ack) acks++;
      end else begin
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
      end
      #1;
      if (busy === 1'b1) busyCycles++;
      if (done === 1'b1) begin
        doneCount++;
        if (doneCycle < 0) begin doneCycle = cyc; vdataAtDone = vdata_out; end
      end
      if (vwrite_en === 1'b1) begin
        vwenCount++;
        if (done !== 1'b1) vwenOffDone++;
      end
      if (err === 1'b1) begin
        errCount++;
        if (errCycle < 0) errCycle = cyc;
      end
      if (doneCycle >= 0 && cyc >= doneCycle + 3) break;
    end
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b0;
  endtask

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*EW +: EW] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    nChecks++; if (mem_req !== 1'b0) begin nFails++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nChecks++; if ({done, vwrite_en, err, mem_we} !== 4'b0) begin nFails++; $display("FAIL reset_pulses: got %b expected 0000", {done, vwrite_en, err, mem_we}); end
    nChecks++; if (vdata_out !== '0) begin nFails++; $display("FAIL reset_vdata: got %h expected 0", vdata_out); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    nChecks++; if ({mem_req, busy, done, err} !== 4'b0) begin nFails++; $display("FAIL idle_after_reset: got %b expected 0000", {mem_req, busy, done, err}); end
  endtask

  task automatic test_store();
    logic [VW-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*EW +: EW] = 32'(8'h11 * l);
    runOp(1'b1, 32'h100, w, randVec(), 1, 1'b0, -1, 40);
    nChecks++; if (rAddr.size() != LANES) begin nFails++; $display("FAIL store_beats: got %0d expected %0d", rAddr.size(), LANES); end
    for (int i = 0; i < rAddr.size(); i++) begin
      nChecks++; if (rAddr[i] !== 32'h100 + 32'(4 * i)) begin nFails++; $display("FAIL store_addr[%0d]: got %h expected %h", i, rAddr[i], 32'h100 + 32'(4 * i)); end
      nChecks++; if (rWdata[i] !== 32'(8'h11 * i) || rWe[i] !== 1'b1) begin nFails++; $display("FAIL store_wdata[%0d]: got %h we %b expected %h we 1", i, rWdata[i], rWe[i], 32'(8'h11 * i)); end
    end
    nChecks++; if (busyCycles != LANES + 1) begin nFails++; $display("FAIL store_busy: got %0d expected %0d", busyCycles, LANES + 1); end
    nChecks++; if (doneCycle != LANES + 1) begin nFails++; $display("FAIL store_done_cycle: got %0d expected %0d", doneCycle, LANES + 1); end
    nChecks++; if (vwenCount != 0 || doneCount != 1) begin nFails++; $display("FAIL store_pulses: vwen %0d done %0d expected 0 and 1", vwenCount, doneCount); end
    nChecks++; if (vdata_out !== modelVdata) begin nFails++; $display("FAIL store_vdata_kept: got %h expected %h", vdata_out, modelVdata); end
  endtask

  task automatic test_load_wait();
    logic [VW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*EW +: EW] = 32'hA0 + 32'(l);
    runOp(1'b0, 32'h200, randVec(), r, 3, 1'b0, -1, 80);
    nChecks++; if (rAddr.size() != 3 * LANES) begin nFails++; $display("FAIL load_req_cycles: got %0d expected %0d", rAddr.size(), 3 * LANES); end
    for (int i = 0; i < rAddr.size(); i++) begin
      nChecks++; if (rAddr[i] !== 32'h200 + 32'(4 * rBeat[i]) || rWe[i] !== 1'b0) begin nFails++; $display("FAIL load_addr[%0d]: got %h we %b expected %h we 0", i, rAddr[i], rWe[i], 32'h200 + 32'(4 * rBeat[i])); end
    end
    nChecks++; if (busyCycles != 3 * LANES + 1) begin nFails++; $display("FAIL load_busy: got %0d expected %0d", busyCycles, 3 * LANES + 1); end
    nChecks++; if (doneCycle != 3 * LANES + 1) begin nFails++; $display("FAIL load_done_cycle: got %0d expected %0d", doneCycle, 3 * LANES + 1); end
    nChecks++; if (vwenCount != 1 || vwenOffDone != 0) begin nFails++; $display("FAIL load_vwen: count %0d off-done %0d expected 1 and 0", vwenCount, vwenOffDone); end
    nChecks++; if (vdataAtDone !== r) begin nFails++; $display("FAIL load_vdata_at_done: got %h expected %h", vdataAtDone, r); end
    modelVdata = r;
    nChecks++; if (vdata_out !== modelVdata) begin nFails++; $display("FAIL load_vdata_hold: got %h expected %h", vdata_out, modelVdata); end
  endtask

  task automatic test_misaligned();
    logic [AW-1:0] bases[2];
    bases[0] = 32'h102;
    bases[1] = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
    for (int k = 0; k < 2; k++) begin
      runOp(1'b0, bases[k], randVec(), randVec(), 1, 1'b0, -1, 5);
      nChecks++; if (errCount != 1 || errCycle != 1) begin nFails++; $display("FAIL misaligned_err[%0d]: count %0d cycle %0d expected 1 and 1", k, errCount, errCycle); end
      nChecks++; if (rAddr.size() != 0 || busyCycles != 0 || doneCount != 0) begin nFails++; $display("FAIL misaligned_quiet[%0d]: reqs %0d busy %0d done %0d expected 0 0 0", k, rAddr.size(), busyCycles, doneCount); end
      nChecks++; if (vdata_out !== modelVdata) begin nFails++; $display("FAIL misaligned_vdata[%0d]: got %h expected %h", k, vdata_out, modelVdata); end
    end
  endtask

  task automatic test_wrap();
    logic [VW-1:0] r = randVec();
    logic [AW-1:0] b = 32'hFFFF_FFF8;
    runOp(1'b0, b, randVec(), r, 1, 1'b0, -1, 40);
    nChecks++; if (rAddr.size() != LANES) begin nFails++; $display("FAIL wrap_beats: got %0d expected %0d", rAddr.size(), LANES); end
    for (int i = 0; i < rAddr.size(); i++) begin
      nChecks++; if (rAddr[i] !== b + 32'(4 * rBeat[i])) begin nFails++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, rAddr[i], b + 32'(4 * rBeat[i])); end
    end
    modelVdata = r;
    nChecks++; if (vdata_out !== modelVdata) begin nFails++; $display("FAIL wrap_vdata: got %h expected %h", vdata_out, modelVdata); end
  endtask

  task automatic test_reset_abort();
    logic [VW-1:0] r = randVec();
    runOp(1'b0, 32'h300, randVec(), randVec(), 1, 1'b0, 3, 40);
    nChecks++; if (!abortReqLow || !abortBusyLow) begin nFails++; $display("FAIL abort_async: mem_req-low %b busy-low %b expected 1 1", abortReqLow, abortBusyLow); end
    nChecks++; if (rAddr.size() != 3) begin nFails++; $display("FAIL abort_beats: got %0d expected 3", rAddr.size()); end
    modelVdata = '0;
    runOp(1'b0, 32'h400, randVec(), r, 1, 1'b0, -1, 40);
    nChecks++; if (rAddr.size() != LANES) begin nFails++; $display("FAIL restart_beats: got %0d expected %0d", rAddr.size(), LANES); end
    for (int i = 0; i < rAddr.size(); i++) begin
      nChecks++; if (rAddr[i] !== 32'h400 + 32'(4 * i)) begin nFails++; $display("FAIL restart_addr[%0d]: got %h expected %h", i, rAddr[i], 32'h400 + 32'(4 * i)); end
    end
    nChecks++; if (doneCycle != LANES + 1) begin nFails++; $display("FAIL restart_done_cycle: got %0d expected %0d", doneCycle, LANES + 1); end
    modelVdata = r;
    nChecks++; if (vdata_out !== modelVdata) begin nFails++; $display("FAIL restart_vdata: got %h expected %h", vdata_out, modelVdata); end
  endtask

  task automatic test_start_held();
    int p = $urandom_range(1, 3);
    runOp(1'b1, 32'h500, randVec(), randVec(), p, 1'b1, -1, 80);
    nChecks++; if (doneCount != 1) begin nFails++; $display("FAIL held_done_count: got %0d expected 1", doneCount); end
    nChecks++; if (rAddr.size() != p * LANES) begin nFails++; $display("FAIL held_req_cycles: got %0d expected %0d", rAddr.size(), p * LANES); end
    nChecks++; if (busyCycles != p * LANES + 1) begin nFails++; $display("FAIL held_busy: got %0d expected %0d", busyCycles, p * LANES + 1); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      logic          st = 1'($urandom);
      logic [AW-1:0] b  = $urandom & 32'hFFFF_FFFC;
      int            p  = $urandom_range(1, 4);
      logic [VW-1:0] w  = randVec();
      logic [VW-1:0] r  = randVec();
      runOp(st, b, w, r, p, 1'b0, -1, 100);
      nChecks++; if (rAddr.size() != p * LANES) begin nFails++; $display("FAIL b2b_req_cycles[%0d]: got %0d expected %0d", n, rAddr.size(), p * LANES); end
      for (int i = 0; i < rAddr.size(); i++) begin
        nChecks++;
        if (rAddr[i] !== b + 32'(4 * rBeat[i]) || rWe[i] !== st || (st && rWdata[i] !== w[rBeat[i]*EW +: EW])) begin
          nFails++;
          $display("FAIL b2b_beat[%0d.%0d]: got addr %h we %b wdata %h expected addr %h we %b", n, i, rAddr[i], rWe[i], rWdata[i], b + 32'(4 * rBeat[i]), st);
        end
      end
      nChecks++; if (doneCycle != p * LANES + 1 || busyCycles != p * LANES + 1) begin nFails++; $display("FAIL b2b_timing[%0d]: done %0d busy %0d expected %0d", n, doneCycle, busyCycles, p * LANES + 1); end
      nChecks++; if (vwenCount != (st ? 0 : 1)) begin nFails++; $display("FAIL b2b_vwen[%0d]: got %0d expected %0d", n, vwenCount, st ? 0 : 1); end
      if (!st) modelVdata = r;
      nChecks++; if (vdata_out !== modelVdata) begin nFails++; $display("FAIL b2b_vdata[%0d]: got %h expected %h", n, vdata_out, modelVdata); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store();
    test_load_wait();
    test_misaligned();
    test_wrap();
    test_reset_abort();
    test_start_held();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
